// File: rtl/channel_error_monitor.sv
// Compares received 66b blocks against their clean reference and accumulates
// saturating error statistics behind a snapshot/clear register interface.
module channel_error_monitor #(
    parameter int unsigned NB_CODED_BLOCK = 66,
    parameter int unsigned NB_BLK_CNT     = 32,
    parameter int unsigned NB_BIT_CNT     = 40,
    parameter int unsigned NB_RUN_CNT     = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic                      i_aligner_tag,
    input  logic [NB_CODED_BLOCK-1:0] i_ref_data,
    input  logic [NB_CODED_BLOCK-1:0] i_rx_data,
    input  logic                      i_rf_clear,
    input  logic                      i_rf_snapshot,
    output logic [NB_BLK_CNT-1:0]     o_total_blocks,
    output logic [NB_BLK_CNT-1:0]     o_err_blocks,
    output logic [NB_BIT_CNT-1:0]     o_err_bits,
    output logic [NB_BLK_CNT-1:0]     o_sh_err_blocks,
    output logic [NB_BLK_CNT-1:0]     o_am_err_blocks,
    output logic [NB_RUN_CNT-1:0]     o_max_err_run,
    output logic                      o_saturated,
    output logic                      o_snapshot_done
);

    localparam int unsigned NB_POP  = $clog2(NB_CODED_BLOCK + 1);
    localparam int unsigned NB_BSUM = ((NB_BIT_CNT > NB_POP) ? NB_BIT_CNT : NB_POP) + 1;

    localparam logic [NB_BLK_CNT-1:0] BLK_MAX = '1;
    localparam logic [NB_BIT_CNT-1:0] BIT_MAX = '1;
    localparam logic [NB_RUN_CNT-1:0] RUN_MAX = '1;

    logic                      s1_valid;
    logic                      s1_tag;
    logic [NB_CODED_BLOCK-1:0] s1_diff;
    logic [NB_POP-1:0]         pop_c;

    logic                      s2_valid;
    logic                      s2_tag;
    logic [NB_POP-1:0]         s2_pop;
    logic                      s2_any;
    logic                      s2_sh;

    logic [NB_BLK_CNT-1:0] tot_q,  tot_d;
    logic [NB_BLK_CNT-1:0] err_q,  err_d;
    logic [NB_BIT_CNT-1:0] bits_q, bits_d;
    logic [NB_BLK_CNT-1:0] sh_q,   sh_d;
    logic [NB_BLK_CNT-1:0] am_q,   am_d;
    logic [NB_RUN_CNT-1:0] cur_q,  cur_d;
    logic [NB_RUN_CNT-1:0] max_q,  max_d;
    logic                  sat_q,  sat_d;
    logic [NB_BSUM-1:0]    bsum;

    // S1: per-bit difference; a clear discards the block sampled on that edge
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_diff  <= '0;
        end else begin
            s1_valid <= i_valid & ~i_rf_clear;
            s1_tag   <= i_aligner_tag;
            s1_diff  <= i_ref_data ^ i_rx_data;
        end
    end

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < NB_CODED_BLOCK; i++) begin
            pop_c = pop_c + NB_POP'(s1_diff[i]);
        end
    end

    // S2: reduced error figures for the block
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
            s2_tag   <= 1'b0;
            s2_pop   <= '0;
            s2_any   <= 1'b0;
            s2_sh    <= 1'b0;
        end else begin
            s2_valid <= s1_valid & ~i_rf_clear;
            s2_tag   <= s1_tag;
            s2_pop   <= pop_c;
            s2_any   <= |s1_diff;
            s2_sh    <= |s1_diff[NB_CODED_BLOCK-1 -: 2];
        end
    end

    // S3: saturating accumulation; bubbles leave every counter, including the run, untouched
    always_comb begin
        tot_d  = tot_q;
        err_d  = err_q;
        bits_d = bits_q;
        sh_d   = sh_q;
        am_d   = am_q;
        cur_d  = cur_q;
        max_d  = max_q;
        bsum   = NB_BSUM'(bits_q) + NB_BSUM'(s2_pop);
        if (s2_valid) begin
            if (tot_q != BLK_MAX) tot_d = tot_q + NB_BLK_CNT'(1);
            if (s2_any && (err_q != BLK_MAX)) err_d = err_q + NB_BLK_CNT'(1);
            bits_d = (bsum > NB_BSUM'(BIT_MAX)) ? BIT_MAX : NB_BIT_CNT'(bsum);
            if (s2_sh && (sh_q != BLK_MAX)) sh_d = sh_q + NB_BLK_CNT'(1);
            if (s2_any && s2_tag && (am_q != BLK_MAX)) am_d = am_q + NB_BLK_CNT'(1);
            if (s2_any) begin
                if (cur_q != RUN_MAX) cur_d = cur_q + NB_RUN_CNT'(1);
                if (cur_d > max_q) max_d = cur_d;
            end else begin
                cur_d = '0;
            end
        end
        sat_d = sat_q | (tot_d == BLK_MAX) | (err_d == BLK_MAX) | (bits_d == BIT_MAX)
              | (sh_d == BLK_MAX) | (am_d == BLK_MAX) | (cur_d == RUN_MAX) | (max_d == RUN_MAX);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_rf_clear) begin
            tot_q  <= '0;
            err_q  <= '0;
            bits_q <= '0;
            sh_q   <= '0;
            am_q   <= '0;
            cur_q  <= '0;
            max_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            tot_q  <= tot_d;
            err_q  <= err_d;
            bits_q <= bits_d;
            sh_q   <= sh_d;
            am_q   <= am_d;
            cur_q  <= cur_d;
            max_q  <= max_d;
            sat_q  <= sat_d;
        end
    end

    // Readout takes the pre-edge live values, so a same-edge clear is still captured first
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_total_blocks  <= '0;
            o_err_blocks    <= '0;
            o_err_bits      <= '0;
            o_sh_err_blocks <= '0;
            o_am_err_blocks <= '0;
            o_max_err_run   <= '0;
            o_saturated     <= 1'b0;
            o_snapshot_done <= 1'b0;
        end else begin
            o_snapshot_done <= i_rf_snapshot;
            if (i_rf_snapshot) begin
                o_total_blocks  <= tot_q;
                o_err_blocks    <= err_q;
                o_err_bits      <= bits_q;
                o_sh_err_blocks <= sh_q;
                o_am_err_blocks <= am_q;
                o_max_err_run   <= max_q;
                o_saturated     <= sat_q;
            end
        end
    end

endmodule

// File: tb/tb_channel_error_monitor.sv
// Scoreboard bench for channel_error_monitor: a wide and a narrow (fast-saturating)
// instance share one stimulus stream and are checked against a queue-based model.
module tb_channel_error_monitor;

    localparam int unsigned NB_CB = 66;
    localparam int unsigned W_BLK = 32, W_BIT = 40, W_RUN = 16;
    localparam int unsigned N_BLK = 4,  N_BIT = 6,  N_RUN = 3;

    logic             i_clock = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_aligner_tag = 1'b0;
    logic [NB_CB-1:0] i_ref_data = '0;
    logic [NB_CB-1:0] i_rx_data = '0;
    logic             i_rf_clear = 1'b0;
    logic             i_rf_snapshot = 1'b0;

    logic [W_BLK-1:0] w_tot, w_err, w_sh, w_am;
    logic [W_BIT-1:0] w_bits;
    logic [W_RUN-1:0] w_run;
    logic             w_sat, w_done;
    logic [N_BLK-1:0] n_tot, n_err, n_sh, n_am;
    logic [N_BIT-1:0] n_bits;
    logic [N_RUN-1:0] n_run;
    logic             n_sat, n_done;

    always #5 i_clock = ~i_clock;

    channel_error_monitor #(.NB_CODED_BLOCK(NB_CB), .NB_BLK_CNT(W_BLK), .NB_BIT_CNT(W_BIT), .NB_RUN_CNT(W_RUN)) u_wide (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_aligner_tag(i_aligner_tag),
        .i_ref_data(i_ref_data), .i_rx_data(i_rx_data), .i_rf_clear(i_rf_clear), .i_rf_snapshot(i_rf_snapshot),
        .o_total_blocks(w_tot), .o_err_blocks(w_err), .o_err_bits(w_bits), .o_sh_err_blocks(w_sh),
        .o_am_err_blocks(w_am), .o_max_err_run(w_run), .o_saturated(w_sat), .o_snapshot_done(w_done));

    channel_error_monitor #(.NB_CODED_BLOCK(NB_CB), .NB_BLK_CNT(N_BLK), .NB_BIT_CNT(N_BIT), .NB_RUN_CNT(N_RUN)) u_narrow (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_aligner_tag(i_aligner_tag),
        .i_ref_data(i_ref_data), .i_rx_data(i_rx_data), .i_rf_clear(i_rf_clear), .i_rf_snapshot(i_rf_snapshot),
        .o_total_blocks(n_tot), .o_err_blocks(n_err), .o_err_bits(n_bits), .o_sh_err_blocks(n_sh),
        .o_am_err_blocks(n_am), .o_max_err_run(n_run), .o_saturated(n_sat), .o_snapshot_done(n_done));

    typedef struct {
        longint tot, err, bits, sh, am, cur, mx;
        bit     sat;
    } stats_t;

    typedef struct {
        stats_t w;
        stats_t n;
    } snap_t;

    typedef struct {
        int  commit;
        bit  tag;
        int  pop;
        bit  any;
        bit  sh;
    } pend_t;

    int     n_checks = 0;
    int     n_pass = 0;
    int     edge_n = 0;
    stats_t m_w, m_n;
    snap_t  exp_q[$];
    pend_t  pend_q[$];

    function automatic longint cap_of(int unsigned w);
        return longint'((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint lmin(longint a, longint b);
        return (a < b) ? a : b;
    endfunction

    function automatic stats_t zero_stats();
        stats_t s;
        s.tot = 0; s.err = 0; s.bits = 0; s.sh = 0; s.am = 0; s.cur = 0; s.mx = 0; s.sat = 1'b0;
        return s;
    endfunction

    // One counted block, with every statistic clamped at its counter's capacity
    function automatic stats_t account(stats_t s, pend_t p, int unsigned wb, int unsigned wbit, int unsigned wr);
        longint bc = cap_of(wb);
        longint tc = cap_of(wbit);
        longint rc = cap_of(wr);
        s.tot  = lmin(s.tot + 1, bc);
        s.err  = lmin(s.err + (p.any ? 1 : 0), bc);
        s.bits = lmin(s.bits + p.pop, tc);
        s.sh   = lmin(s.sh + (p.sh ? 1 : 0), bc);
        s.am   = lmin(s.am + ((p.any && p.tag) ? 1 : 0), bc);
        s.cur  = p.any ? lmin(s.cur + 1, rc) : 0;
        if (s.cur > s.mx) s.mx = s.cur;
        if (s.tot == bc || s.err == bc || s.bits == tc || s.sh == bc || s.am == bc || s.cur == rc || s.mx == rc)
            s.sat = 1'b1;
        return s;
    endfunction

    // Reference model: a block sampled at edge E is counted at edge E+2 unless a clear lands first
    always @(posedge i_clock) begin
        edge_n++;
        if (i_reset) begin
            m_w = zero_stats();
            m_n = zero_stats();
            pend_q.delete();
        end else begin
            if (i_rf_snapshot) exp_q.push_back('{w: m_w, n: m_n});
            if (i_rf_clear) begin
                m_w = zero_stats();
                m_n = zero_stats();
                pend_q.delete();
            end else begin
                while (pend_q.size() > 0 && pend_q[0].commit == edge_n) begin
                    m_w = account(m_w, pend_q[0], W_BLK, W_BIT, W_RUN);
                    m_n = account(m_n, pend_q[0], N_BLK, N_BIT, N_RUN);
                    void'(pend_q.pop_front());
                end
                if (i_valid) begin
                    pend_t p;
                    logic [NB_CB-1:0] d;
                    d = i_ref_data ^ i_rx_data;
                    p.commit = edge_n + 2;
                    p.tag    = i_aligner_tag;
                    p.pop    = $countones(d);
                    p.any    = (d != '0);
                    p.sh     = (d[NB_CB-1 -: 2] != 2'b00);
                    pend_q.push_back(p);
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: every snapshot_done pulse consumes one expected snapshot
    always @(negedge i_clock) begin
        if (!i_reset && (w_done || n_done)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                snap_t e;
                e = exp_q.pop_front();
                chk("w_done", longint'(w_done), 1);
                chk("w_total", longint'(w_tot), e.w.tot);
                chk("w_err_blocks", longint'(w_err), e.w.err);
                chk("w_err_bits", longint'(w_bits), e.w.bits);
                chk("w_sh_err", longint'(w_sh), e.w.sh);
                chk("w_am_err", longint'(w_am), e.w.am);
                chk("w_max_run", longint'(w_run), e.w.mx);
                chk("w_saturated", longint'(w_sat), longint'(e.w.sat));
                chk("n_done", longint'(n_done), 1);
                chk("n_total", longint'(n_tot), e.n.tot);
                chk("n_err_blocks", longint'(n_err), e.n.err);
                chk("n_err_bits", longint'(n_bits), e.n.bits);
                chk("n_sh_err", longint'(n_sh), e.n.sh);
                chk("n_am_err", longint'(n_am), e.n.am);
                chk("n_max_run", longint'(n_run), e.n.mx);
                chk("n_saturated", longint'(n_sat), longint'(e.n.sat));
            end
        end
    end

    task automatic cyc(input bit v, input bit tag, input logic [NB_CB-1:0] rf, input logic [NB_CB-1:0] rx,
                       input bit snap, input bit clr);
        i_valid = v; i_aligner_tag = tag; i_ref_data = rf; i_rx_data = rx;
        i_rf_snapshot = snap; i_rf_clear = clr;
        @(posedge i_clock);
        #1;
    endtask

    function automatic logic [NB_CB-1:0] rnd66();
        return NB_CB'({$urandom, $urandom, $urandom});
    endfunction

    function automatic logic [NB_CB-1:0] err_mask(int nbits, bit flip_sh);
        logic [NB_CB-1:0] m = '0;
        for (int k = 0; k < nbits; k++) m[$urandom_range(NB_CB - 3, 0)] = 1'b1;
        if (flip_sh) m[NB_CB-1 -: 2] = 2'($urandom_range(3, 1));
        return m;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, rnd66(), rnd66(), 0, 0);
    endtask

    task automatic blk(input bit tag, input logic [NB_CB-1:0] m, input bit snap);
        logic [NB_CB-1:0] r;
        r = rnd66();
        cyc(1, tag, r, r ^ m, snap, 0);
    endtask

    task automatic snap_now();
        idle(3);
        cyc(0, 0, '0, '0, 1, 0);
        idle(2);
    endtask

    task automatic clear_now();
        cyc(0, 0, '0, '0, 0, 1);
    endtask

    initial begin
        logic [NB_CB-1:0] m3;
        logic [NB_CB-1:0] r;
        m3 = NB_CB'(66'h7);
        i_reset = 1'b1;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        chk("rst_w_total", longint'(w_tot), 0);
        chk("rst_w_err_bits", longint'(w_bits), 0);
        chk("rst_w_max_run", longint'(w_run), 0);
        chk("rst_w_saturated", longint'(w_sat), 0);
        chk("rst_w_done", longint'(w_done), 0);
        chk("rst_n_total", longint'(n_tot), 0);
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;

        // T1: clean stream
        for (int k = 0; k < 100; k++) blk(0, '0, 0);
        snap_now();
        // T2: 3-bit payload errors then clean
        clear_now();
        for (int k = 0; k < 10; k++) blk(0, m3, 0);
        for (int k = 0; k < 10; k++) blk(0, '0, 0);
        snap_now();
        // T3: tagged sync-header flips 01->10 with errored-looking bubbles between
        clear_now();
        for (int k = 0; k < 5; k++) begin
            r = rnd66();
            r[NB_CB-1 -: 2] = 2'b01;
            cyc(1, 1, r, {2'b10, r[NB_CB-3:0]}, 0, 0);
            cyc(0, 1, rnd66(), rnd66(), 0, 0);
        end
        snap_now();
        // T4: runs of 3, 7, 2, then a snapshot inside a 7-run
        clear_now();
        for (int k = 0; k < 3; k++) blk(0, m3, 0);
        blk(0, '0, 0);
        for (int k = 0; k < 7; k++) begin
            blk(0, err_mask(1, 0), 0);
            if (k == 3) cyc(0, 0, '0, '1, 0, 0);
        end
        blk(0, '0, 0);
        for (int k = 0; k < 2; k++) blk(0, m3, 0);
        blk(0, '0, 0);
        snap_now();
        clear_now();
        for (int k = 0; k < 7; k++) blk(0, m3, k == 6);
        snap_now();
        // T5: saturation (narrow instance) and clear recovery
        clear_now();
        for (int k = 0; k < 20; k++) blk(0, m3, 0);
        snap_now();
        clear_now();
        snap_now();
        // T6: snapshot and clear on the same edge with blocks in flight
        clear_now();
        for (int k = 0; k < 14; k++) blk(0, m3, 0);
        r = rnd66();
        cyc(1, 0, r, r ^ m3, 1, 1);
        snap_now();
        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bit v, tg, sn, cl;
            int kind;
            logic [NB_CB-1:0] m;
            v  = ($urandom_range(3, 0) != 0);
            tg = ($urandom_range(7, 0) == 0);
            sn = ($urandom_range(15, 0) == 0);
            cl = ($urandom_range(96, 0) == 0);
            kind = $urandom_range(9, 0);
            m = (kind < 5) ? '0 : err_mask($urandom_range(4, 0), kind == 9);
            r = rnd66();
            cyc(v, tg, r, r ^ m, sn, cl);
        end
        snap_now();
        idle(4);
        chk("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
